// File: rtl/noc_merge2_if.sv
`default_nettype none
// ============================================================================
//  Module      : noc_merge2_if
//  Description : Handshake bundle for the two-input NoC merge stage. Carries
//                both upstream flit channels and the merged output channel.
//                The slave modport is the merge block's view and the master
//                modport is the view of the surrounding fabric.
//  Revision    : 1.0 - initial release
// ============================================================================
interface noc_merge2_if #(
    parameter int W = 9
);
    logic [W-1:0] in0_data;
    logic         in0_valid;
    logic         in0_ready;
    logic [W-1:0] in1_data;
    logic         in1_valid;
    logic         in1_ready;
    logic [W-1:0] out_data;
    logic         out_src;
    logic         out_valid;
    logic         out_ready;

    modport slave (
        input  in0_data, in0_valid, in1_data, in1_valid, out_ready,
        output in0_ready, in1_ready, out_data, out_src, out_valid
    );

    modport master (
        output in0_data, in0_valid, in1_data, in1_valid, out_ready,
        input  in0_ready, in1_ready, out_data, out_src, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/noc_merge2.sv
`default_nettype none
// ============================================================================
//  Module      : noc_merge2
//  Description : Two-input round-robin merge stage with an output FIFO.
//                Each stored flit carries a source tag (0 = in0, 1 = in1).
//                Optional per-input accept counters are compiled in when the
//                macro NOC_MERGE2_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module noc_merge2 #(
    parameter int W     = 9,
    parameter int DEPTH = 2
) (
    input  wire logic   CLK,
    input  wire logic   RESET,
    noc_merge2_if.slave bus
`ifdef NOC_MERGE2_STATS_EN
    ,
    input  wire logic   stat_clr,
    output logic [15:0] stat0,
    output logic [15:0] stat1
`endif
);

    localparam int              c_AW        = $clog2(DEPTH);
    localparam int              c_CW        = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);

    logic [W:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_rr_last;

    logic            w_space;
    logic            w_grant0;
    logic            w_grant1;
    logic            w_push;
    logic            w_pop;
    logic [W:0]      w_wentry;

    // Space is offered whenever a slot is free or the head is leaving this
    // cycle; readies are held low throughout reset.
    always_comb begin
        w_space  = !RESET && ((r_count < c_DEPTH_CNT) || bus.out_ready);
        w_grant0 = w_space && bus.in0_valid && (!bus.in1_valid || r_rr_last);
        w_grant1 = w_space && bus.in1_valid && (!bus.in0_valid || !r_rr_last);
        w_push   = w_grant0 || w_grant1;
        w_pop    = (r_count != '0) && bus.out_ready;
        w_wentry = w_grant1 ? {1'b1, bus.in1_data} : {1'b0, bus.in0_data};
    end

    assign bus.in0_ready = w_grant0;
    assign bus.in1_ready = w_grant1;
    assign bus.out_valid = (r_count != '0);
    assign bus.out_data  = r_mem[r_rd_ptr][W-1:0];
    assign bus.out_src   = r_mem[r_rd_ptr][W];

    // FIFO storage: granted flit and its source tag land at the write pointer.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_wentry;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Round-robin history: resets to 1 so in0 wins the first contention.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rr_last <= 1'b1;
        end else if (w_push) begin
            r_rr_last <= w_grant1;
        end
    end

`ifdef NOC_MERGE2_STATS_EN
    logic [15:0] r_stat0;
    logic [15:0] r_stat1;

    // Per-input accept counters; a clear takes priority over a same-cycle accept.
    always_ff @(posedge CLK) begin
        if (RESET || stat_clr) begin
            r_stat0 <= '0;
            r_stat1 <= '0;
        end else begin
            if (w_grant0) r_stat0 <= r_stat0 + 16'd1;
            if (w_grant1) r_stat1 <= r_stat1 + 16'd1;
        end
    end

    assign stat0 = r_stat0;
    assign stat1 = r_stat1;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_merge2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_noc_merge2
//  Description : Scoreboard bench for noc_merge2. Stimulus pushes expected
//                {src, data} entries; a negedge monitor pops and compares on
//                every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_merge2;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    noc_merge2_if #(.W(9)) bus ();

`ifdef NOC_MERGE2_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat0;
    logic [15:0] stat1;
`endif

    noc_merge2 #(.W(9), .DEPTH(2)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .bus      (bus.slave)
`ifdef NOC_MERGE2_STATS_EN
        ,
        .stat_clr (stat_clr),
        .stat0    (stat0),
        .stat1    (stat1)
`endif
    );

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         errors = 0;
    logic [9:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the scoreboard head.
    always @(negedge CLK) begin
        if (!RESET && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected actual=%0h expected=none", {bus.out_src, bus.out_data});
            end else begin
                chk("out_flit", {22'd0, bus.out_src, bus.out_data}, {22'd0, sb.pop_front()});
            end
        end
    end

    // Bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        tick();
        RESET         = 1'b1;
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        RESET = 1'b0;
        sb.delete();
    endtask

    task automatic drain(input string name);
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int g = 0; g < 50; g++) begin
            tick();
            #3;
            if (!bus.out_valid) break;
        end
        chk({name, "_empty"}, {31'd0, bus.out_valid}, 32'd0);
        chk({name, "_sb"}, sb.size(), 32'd0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int  i0;
        int  i1;
        int  k;
        logic r0;
        logic r1;

        bus.in0_data  = '0;
        bus.in1_data  = '0;
        bus.in0_valid = 1'b1;
        bus.in1_valid = 1'b1;
        bus.out_ready = 1'b0;

        // Reset state with both inputs requesting.
        tick();
        tick();
        #3;
        chk("rst_in0_ready", {31'd0, bus.in0_ready}, 32'd0);
        chk("rst_in1_ready", {31'd0, bus.in1_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", {23'd0, bus.out_data}, 32'd0);
        chk("rst_out_src", {31'd0, bus.out_src}, 32'd0);
        do_reset();

        // Single-input flit.
        bus.in0_valid = 1'b1;
        bus.in0_data  = 9'h1A5;
        sb.push_back({1'b0, 9'h1A5});
        #3;
        chk("single_in0_ready", {31'd0, bus.in0_ready}, 32'd1);
        chk("single_in1_ready", {31'd0, bus.in1_ready}, 32'd0);
        tick();
        bus.in0_valid = 1'b0;
        #3;
        chk("single_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("single_data", {23'd0, bus.out_data}, 32'h1A5);
        chk("single_src", {31'd0, bus.out_src}, 32'd0);
        drain("single");

        // Contention with round-robin, out_ready high.
        do_reset();
        sb.push_back({1'b0, 9'h101});
        sb.push_back({1'b1, 9'h0F1});
        sb.push_back({1'b0, 9'h102});
        sb.push_back({1'b1, 9'h0F2});
        sb.push_back({1'b0, 9'h103});
        sb.push_back({1'b1, 9'h0F3});
        i0 = 0;
        i1 = 0;
        bus.in0_valid = 1'b1;
        bus.in1_valid = 1'b1;
        bus.in0_data  = 9'h101;
        bus.in1_data  = 9'h0F1;
        bus.out_ready = 1'b1;
        for (int g = 0; g < 20 && (i0 < 3 || i1 < 3); g++) begin
            #3;
            r0 = bus.in0_ready;
            r1 = bus.in1_ready;
            if (bus.in0_valid && bus.in1_valid)
                chk("rr_one_grant", {30'd0, r0, r1}, (g % 2 == 0) ? 32'h2 : 32'h1);
            tick();
            if (r0) begin
                i0++;
                bus.in0_data = 9'h101 + 9'(i0);
                if (i0 == 3) bus.in0_valid = 1'b0;
            end
            if (r1) begin
                i1++;
                bus.in1_data = 9'h0F1 + 9'(i1);
                if (i1 == 3) bus.in1_valid = 1'b0;
            end
        end
        chk("rr_all_sent", i0 + i1, 32'd6);
        drain("rr");

        // Full backpressure on in1, then simultaneous pop and push.
        do_reset();
        sb.push_back({1'b1, 9'h011});
        sb.push_back({1'b1, 9'h022});
        sb.push_back({1'b1, 9'h033});
        bus.in1_valid = 1'b1;
        bus.in1_data  = 9'h011;
        #3;
        chk("bp_acc1", {31'd0, bus.in1_ready}, 32'd1);
        tick();
        bus.in1_data = 9'h022;
        #3;
        chk("bp_acc2", {31'd0, bus.in1_ready}, 32'd1);
        tick();
        bus.in1_data = 9'h033;
        #3;
        chk("bp_full_ready", {31'd0, bus.in1_ready}, 32'd0);
        chk("bp_head", {23'd0, bus.out_data}, 32'h011);
        tick();
        bus.out_ready = 1'b1;
        #3;
        chk("bp_passthru_ready", {31'd0, bus.in1_ready}, 32'd1);
        tick();
        bus.out_ready = 1'b0;
        bus.in1_data  = 9'h044;
        #3;
        chk("bp_still_full", {31'd0, bus.in1_ready}, 32'd0);
        chk("bp_head2", {23'd0, bus.out_data}, 32'h022);
        drain("bp");

        // Pointer wrap with random backpressure.
        do_reset();
        for (int n = 0; n < 10; n++) sb.push_back({1'b0, 9'(n)});
        k = 0;
        bus.in0_valid = 1'b1;
        bus.in0_data  = 9'h000;
        for (int g = 0; g < 200 && k < 10; g++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            #3;
            r0 = bus.in0_ready;
            tick();
            if (r0) begin
                k++;
                bus.in0_data = 9'(k);
                if (k == 10) bus.in0_valid = 1'b0;
            end
        end
        chk("wrap_all_sent", k, 32'd10);
        drain("wrap");

        // Reset mid-operation with two flits buffered.
        do_reset();
        bus.in0_valid = 1'b1;
        bus.in0_data  = 9'h0AA;
        tick();
        bus.in0_data = 9'h0BB;
        tick();
        RESET         = 1'b1;
        bus.in1_valid = 1'b1;
        bus.in0_data  = 9'h0C1;
        bus.in1_data  = 9'h0D1;
        #3;
        chk("midrst_in0_ready", {31'd0, bus.in0_ready}, 32'd0);
        chk("midrst_in1_ready", {31'd0, bus.in1_ready}, 32'd0);
        tick();
        RESET = 1'b0;
        #3;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_grant", {30'd0, bus.in0_ready, bus.in1_ready}, 32'h2);
        sb.push_back({1'b0, 9'h0C1});
        tick();
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        #3;
        chk("midrst_head", {22'd0, bus.out_src, bus.out_data}, 32'h0C1);
        drain("midrst");

`ifdef NOC_MERGE2_STATS_EN
        // Accept counters and clear priority.
        do_reset();
        #3;
        chk("stat0_rst", {16'd0, stat0}, 32'd0);
        bus.out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            bus.in0_valid = (n < 3);
            bus.in1_valid = (n >= 3);
            bus.in0_data  = 9'h150 + 9'(n);
            bus.in1_data  = 9'h050 + 9'(n);
            if (n < 3) sb.push_back({1'b0, 9'h150 + 9'(n)});
            else       sb.push_back({1'b1, 9'h050 + 9'(n)});
            tick();
        end
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        #3;
        chk("stat0_count", {16'd0, stat0}, 32'd3);
        chk("stat1_count", {16'd0, stat1}, 32'd5);
        tick();
        bus.in0_valid = 1'b1;
        bus.in0_data  = 9'h1EE;
        stat_clr      = 1'b1;
        sb.push_back({1'b0, 9'h1EE});
        #3;
        chk("stat_clr_accept", {31'd0, bus.in0_ready}, 32'd1);
        tick();
        stat_clr      = 1'b0;
        bus.in0_valid = 1'b0;
        #3;
        chk("stat0_cleared", {16'd0, stat0}, 32'd0);
        chk("stat1_cleared", {16'd0, stat1}, 32'd0);
        drain("stat");
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noc_merge2.md
Name: noc_merge2

Overview:
- Two-input merge stage that sits directly downstream of the 1-to-2 address decoder/router in the NoC fabric.
- Collects flits from two upstream branches, e.g. decoder Out1 from one router and Out0 from a neighbour, and arbitrates them onto one output channel using round-robin.
- Buffers granted flits in a small output FIFO.
- Carries a source tag with each flit, analogous to the decoder's S side channel, so the consumer knows which branch each flit came from.

Parameters:
- W, 9, flit width in bits. Bits [8:5] are the address nibble and pass through unmodified.
- DEPTH, 2, output FIFO depth in entries. Must be >= 2 and a power of 2.

Ports:
- CLK  input  1  clock, all state on rising edge
- RESET  input  1  synchronous, active-high reset
- in0_data  input  W  flit from branch 0
- in0_valid  input  1  branch 0 flit present
- in0_ready  output  1  branch 0 flit accepted this cycle
- in1_data  input  W  flit from branch 1
- in1_valid  input  1  branch 1 flit present
- in1_ready  output  1  branch 1 flit accepted this cycle
- out_data  output  W  head-of-FIFO flit
- out_src  output  1  source tag of head flit (0 = in0, 1 = in1)
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts head flit

Behaviour:
- Handshake:
  - A transfer occurs on any channel when valid && ready are both high at a rising CLK.
  - Upstream must hold data stable while valid is high and ready is low.
- Reset: synchronous; RESET high at a CLK edge gives:
  - count = 0, read/write pointers = 0.
  - rr_last = 1, so in0 wins the first contention.
  - out_valid = 0; out_data and out_src = 0; in0_ready = in1_ready = 0 while RESET is high.
  - Reset mid-operation discards all buffered flits immediately. No output handshake completes in the reset cycle.
- Space:
  - space = (count < DEPTH) || out_ready.
  - Combinational path out_ready -> inX_ready is intentional; it allows full-throughput push and pop when full.
- Arbitration is combinational each cycle, and only when space = 1:
  - only in0_valid -> grant 0
  - only in1_valid -> grant 1
  - both valid -> grant !rr_last
  - neither valid -> no grant
- Ready generation: in0_ready = grant0, in1_ready = grant1. At most one ready is high per cycle. Ready is never asserted without the matching valid.
- On a grant:
  - {src, data} is written at wr_ptr, wr_ptr increments, and rr_last <= granted index.
  - rr_last is unchanged when there is no grant.
- Pop: on out_valid && out_ready, rd_ptr increments.
- Pointer wrap: both pointers wrap modulo DEPTH.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged
  - Count never exceeds DEPTH and never underflows.
- Output timing:
  - out_data and out_src are driven from FIFO storage at rd_ptr.
  - out_valid = (count != 0).
  - Latency: a flit accepted at edge N is visible on out_* after edge N, in cycle N+1. There is no same-cycle bypass.
- Throughput: one flit per cycle sustained when out_ready is held high.
- Fairness: with both inputs continuously valid, grants alternate 0, 1, 0, 1, ...
- Data is passed bit-exact; no field of the flit is modified.
- Empty with out_ready high: no pop, state unchanged.

Optional Feature:
- Macro: NOC_MERGE2_STATS_EN.
- When defined, the block adds outputs stat0 and stat1, each 16 bits, plus input stat_clr (1 bit).
- Each stat counter increments on every accepted flit from its input and wraps from 16'hFFFF to 0.
- RESET or stat_clr clears both counters. If stat_clr and an accept occur in the same cycle, the clear wins and the counter becomes 0.
- When the macro is not defined, these ports and counters are absent and core behaviour is identical.

Test Plan:
- Single-input flit: reset, then in0_valid=1 with in0_data=9'h1A5 for one cycle, out_ready=0 -> in0_ready=1 that cycle. Next cycle: out_valid=1, out_data=9'h1A5, out_src=0.
- Contention and round-robin: both inputs valid continuously, in0 sending 9'h101, 9'h102, ... and in1 sending 9'h0F1, 9'h0F2, ..., out_ready=1 -> output sequence 101/src0, 0F1/src1, 102/src0, 0F2/src1, one flit per cycle after the first.
- Full backpressure: out_ready=0, in1 streams 9'h011, 9'h022, 9'h033 -> first two accepted, then in1_ready=0 and count=2. Raising out_ready -> 011 pops and 033 is accepted in the same cycle; count stays 2.
- Pointer wrap: push and pop 10 flits 9'h000..9'h009 with randomly toggled out_ready -> output order identical to input, no loss or duplication, count returns to 0 and out_valid=0.
- Reset mid-operation: FIFO holding 2 flits, assert RESET for one cycle with both inputs valid -> out_valid=0 next cycle, no ready asserted during reset. The first post-reset contention grants in0.
- Stats, with NOC_MERGE2_STATS_EN defined: 3 in0 flits and 5 in1 flits -> stat0=3, stat1=5. Pulse stat_clr together with an in0 accept -> stat0=0.
